window_generator_3x3: RTL and testbench
=======================================

Name: window_generator_3x3

Overview:
- Streaming front-end that turns a raster-order 8-bit pixel stream into 3x3 neighbourhoods for the downstream 3x3 weighted window filter.
- Drives the nine window taps, numbered 1..9 in row-major order with 5 as the centre.
- Holds the previous two image rows in two line buffers and the last three columns in a 3x3 register array.
- Emits one registered window per accepted input pixel once the window lies fully inside the frame.

Parameters:
- IMG_W, 512, pixels per row (>= 3).
- IMG_H, 512, rows per frame (>= 3).
- DATA_W, 8, bits per pixel.

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_pixel is valid this cycle. No backpressure: every in_valid cycle is accepted.
- in_sof  in  1  start of frame. Qualified by in_valid; marks the pixel as (row 0, col 0).
- in_pixel  in  DATA_W  raster-order pixel.
- out_valid  out  1  window taps valid this cycle.
- out_pixel_1..out_pixel_9  out  DATA_W each  window taps. Tap 1 = (r-2, c-2), tap 3 = (r-2, c), tap 5 = (r-1, c-1), tap 7 = (r, c-2), tap 9 = (r, c), where (r, c) is the newest pixel.
- out_row  out  clog2(IMG_H)  row of the centre tap (r-1).
- out_col  out  clog2(IMG_W)  column of the centre tap (c-1).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset:
  - Synchronous, active-high; clk and rst only.
  - All outputs go to 0 and the row/col counters go to 0.
  - Line-buffer contents are not cleared; stale data is masked by the validity rule below.
- Accept: every cycle with in_valid=1. Cycles with in_valid=0 hold all state, and out_valid goes to 0 the next cycle.
- Counters:
  - col increments per accept.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - At (row == IMG_H-1, col == IMG_W-1), both counters wrap to 0 and frame_done pulses on the next cycle.
- SOF:
  - in_valid && in_sof forces the pixel to be treated as (0, 0), regardless of the counters. The counters become (0, 1) afterwards.
  - This is legal mid-frame (resync); no frame_done is issued for the aborted frame.
- Datapath, on each accept at (row, col):
  - Read lb0[col] (row r-1) and lb1[col] (row r-2).
  - Write lb1[col] <= lb0[col] and lb0[col] <= in_pixel (read-before-write, same address).
  - Shift the 3x3 array one column left. The new right column is {lb1[col], lb0[col], in_pixel} for top, middle, bottom.
- Validity and latency:
  - out_valid=1 exactly 1 cycle after an accept with row >= 2 and col >= 2.
  - The taps, out_row and out_col are registered in that same cycle.
  - Windows never straddle rows. The col >= 2 gate flushes previous-row columns from the array.
- Count: windows per frame = (IMG_W-2)*(IMG_H-2). Frame borders are not emitted; no padding.
- Taps hold their last values when out_valid=0 (don't-care for consumers).
- Reset mid-frame: output state is identical to post-reset. The next accepted pixel is (0, 0) whether or not in_sof is set.
- Simultaneous frame end and in_sof: in_sof wins. The counters restart and frame_done is still pulsed, because the last pixel of the previous frame was accepted earlier.
- No arithmetic on pixel data; the block is pure storage and routing.

Decomposition:
- Shared package:
  - DATA_W default.
  - IMG_W and IMG_H defaults.
  - Counter-width constants via clog2.
  - Tap-index constants TAP_TL..TAP_BR (1..9) shared with the window filter.
- One sub-module, line_buffer:
  - Depth IMG_W, width DATA_W.
  - Asynchronous read, synchronous write, read-before-write on the same address.
  - Instantiated twice (lb0, lb1).
- Counters, the 3x3 array and output registers live in window_generator_3x3.

Test Plan:
- Ramp frame, IMG_W=5, IMG_H=4, pixel = 10*row+col, continuous in_valid -> 6 windows with out_row/out_col covering 1..2 and 1..3. The first window has taps 0,1,2,10,11,12,20,21,22, one cycle after pixel 22 is accepted. frame_done pulses one cycle after pixel 34.
- Same frame with in_valid toggling 1/0 -> identical window sequence, with out_valid only on the cycles after accepts.
- Row wrap: check no window is emitted for centres at col 0 or IMG_W-1. The window after the wrap (centre (2,1)) has taps 10,11,12,20,21,22,30,31,32.
- in_sof asserted mid-frame at row 2 col 3, followed by a fresh ramp -> no frame_done for the aborted frame. The next window is emitted only after the new (2,2), with taps from the new frame only.
- rst for one cycle mid-frame -> all outputs 0 on the next cycle. A full frame restarted afterwards yields exactly 6 correct windows.
- Two back-to-back frames without a gap -> frame_done pulses once per frame, and window 1 of frame 2 contains no frame-1 data.

Source files
------------

// File: rtl/window_generator_3x3_pkg.sv
// Shared definitions for the 3x3 window generator and the downstream window filter.
// Tap numbering is row-major, 1 = top-left, 5 = centre, 9 = bottom-right (newest pixel).
package window_generator_3x3_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 512;
  localparam int IMG_H_DEF  = 512;

  localparam int TAP_TL = 1;
  localparam int TAP_TC = 2;
  localparam int TAP_TR = 3;
  localparam int TAP_ML = 4;
  localparam int TAP_MC = 5;
  localparam int TAP_MR = 6;
  localparam int TAP_BL = 7;
  localparam int TAP_BC = 8;
  localparam int TAP_BR = 9;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_generator_3x3_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle returns the old contents.
module window_generator_3x3_line_buffer
  import window_generator_3x3_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [cnt_width(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_generator_3x3.sv
// Turns a raster-order pixel stream into registered 3x3 neighbourhoods, using two
// line buffers for the previous rows and a 3x3 register array for the last three columns.
module window_generator_3x3
  import window_generator_3x3_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [DATA_W-1:0]           in_pixel,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_pixel_1,
  output logic [DATA_W-1:0]           out_pixel_2,
  output logic [DATA_W-1:0]           out_pixel_3,
  output logic [DATA_W-1:0]           out_pixel_4,
  output logic [DATA_W-1:0]           out_pixel_5,
  output logic [DATA_W-1:0]           out_pixel_6,
  output logic [DATA_W-1:0]           out_pixel_7,
  output logic [DATA_W-1:0]           out_pixel_8,
  output logic [DATA_W-1:0]           out_pixel_9,
  output logic [cnt_width(IMG_H)-1:0] out_row,
  output logic [cnt_width(IMG_W)-1:0] out_col,
  output logic                        frame_done
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  eff_row;
  logic [COL_W-1:0]  eff_col;
  logic              accept;
  logic              col_end;
  logic              frame_end;
  logic              win_ok;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] win   [3][3];
  logic [DATA_W-1:0] tap_d [1:9];
  logic [DATA_W-1:0] tap_q [1:9];

  assign accept = in_valid && !rst;

  // A start-of-frame pixel is always (0, 0), whatever the counters currently say.
  always_comb begin
    eff_row = row;
    eff_col = col;
    if (in_sof) begin
      eff_row = '0;
      eff_col = '0;
    end
  end

  assign col_end   = (eff_col == COL_LAST);
  assign frame_end = col_end && (eff_row == ROW_LAST);
  assign win_ok    = (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);

  window_generator_3x3_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (eff_col),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  window_generator_3x3_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (eff_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= frame_end ? '0 : eff_row + ROW_W'(1);
      end else begin
        col <= eff_col + COL_W'(1);
        row <= eff_row;
      end
    end
  end

  // Column 2 of the array is the newest column; rows are top (r-2), middle, bottom (r).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= in_pixel;
    end
  end

  // The window as it will look once this accept has shifted into the array.
  always_comb begin
    tap_d[TAP_TL] = win[0][1];
    tap_d[TAP_TC] = win[0][2];
    tap_d[TAP_TR] = lb1_rd;
    tap_d[TAP_ML] = win[1][1];
    tap_d[TAP_MC] = win[1][2];
    tap_d[TAP_MR] = lb0_rd;
    tap_d[TAP_BL] = win[2][1];
    tap_d[TAP_BC] = win[2][2];
    tap_d[TAP_BR] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int k = 1; k <= 9; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      out_valid  <= accept && win_ok;
      frame_done <= accept && frame_end;
      if (accept && win_ok) begin
        out_row <= eff_row - ROW_W'(1);
        out_col <= eff_col - COL_W'(1);
        for (int k = 1; k <= 9; k++) begin
          tap_q[k] <= tap_d[k];
        end
      end
    end
  end

  assign out_pixel_1 = tap_q[TAP_TL];
  assign out_pixel_2 = tap_q[TAP_TC];
  assign out_pixel_3 = tap_q[TAP_TR];
  assign out_pixel_4 = tap_q[TAP_ML];
  assign out_pixel_5 = tap_q[TAP_MC];
  assign out_pixel_6 = tap_q[TAP_MR];
  assign out_pixel_7 = tap_q[TAP_BL];
  assign out_pixel_8 = tap_q[TAP_BC];
  assign out_pixel_9 = tap_q[TAP_BR];

endmodule

// File: tb/tb_window_generator_3x3.sv
// Directed bench for window_generator_3x3 on a 5x4 frame of ramp pixels (base + 10*row + col).
module tb_window_generator_3x3;

  localparam int W = 5;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] out_pixel_1, out_pixel_2, out_pixel_3;
  logic [7:0] out_pixel_4, out_pixel_5, out_pixel_6;
  logic [7:0] out_pixel_7, out_pixel_8, out_pixel_9;
  logic [1:0] out_row;
  logic [2:0] out_col;
  logic       frame_done;
  logic [7:0] taps [9];

  int checks = 0;
  int errors = 0;

  window_generator_3x3 #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_pixel_1 (out_pixel_1),
    .out_pixel_2 (out_pixel_2),
    .out_pixel_3 (out_pixel_3),
    .out_pixel_4 (out_pixel_4),
    .out_pixel_5 (out_pixel_5),
    .out_pixel_6 (out_pixel_6),
    .out_pixel_7 (out_pixel_7),
    .out_pixel_8 (out_pixel_8),
    .out_pixel_9 (out_pixel_9),
    .out_row     (out_row),
    .out_col     (out_col),
    .frame_done  (frame_done)
  );

  assign taps[0] = out_pixel_1;
  assign taps[1] = out_pixel_2;
  assign taps[2] = out_pixel_3;
  assign taps[3] = out_pixel_4;
  assign taps[4] = out_pixel_5;
  assign taps[5] = out_pixel_6;
  assign taps[6] = out_pixel_7;
  assign taps[7] = out_pixel_8;
  assign taps[8] = out_pixel_9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one cycle of input and returns 1ns after the edge that sampled it.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  // Streams npix ramp pixels from (0,0), optionally with idle cycles between them.
  task automatic test_frame(input bit gap, input int base, input bit use_sof,
                            input int npix, input string tag);
    int r, c, nwin;
    logic ev, ef;
    logic [7:0] exp_tap;
    nwin = 0;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      applyStimulus(1'b1, use_sof && (i == 0), 8'(base + 10 * r + c));
      ev = (r >= 2) && (c >= 2);
      ef = (i == NPIX - 1);
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("[TB] FAIL %s_valid px%0d: got %b expected %b", tag, i, out_valid, ev);
      end
      checks++;
      if (frame_done !== ef) begin
        errors++;
        $display("[TB] FAIL %s_frame_done px%0d: got %b expected %b", tag, i, frame_done, ef);
      end
      if (out_valid === 1'b1 && ev) begin
        nwin++;
        checks++;
        if (out_row !== 2'(r - 1) || out_col !== 3'(c - 1)) begin
          errors++;
          $display("[TB] FAIL %s_pos px%0d: got (%0d,%0d) expected (%0d,%0d)",
                   tag, i, out_row, out_col, r - 1, c - 1);
        end
        for (int k = 0; k < 9; k++) begin
          exp_tap = 8'(base + 10 * (r - 2 + k / 3) + (c - 2 + k % 3));
          checks++;
          if (taps[k] !== exp_tap) begin
            errors++;
            $display("[TB] FAIL %s_tap%0d px%0d: got %0d expected %0d",
                     tag, k + 1, i, taps[k], exp_tap);
          end
        end
      end
      if (gap) begin
        applyStimulus(1'b0, 1'b0, 8'hEE);
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s_idle px%0d: got valid=%b done=%b expected 0 0",
                   tag, i, out_valid, frame_done);
        end
      end
    end
    if (npix == NPIX) begin
      checks++;
      if (nwin != 6) begin
        errors++;
        $display("[TB] FAIL %s_count: got %0d expected 6", tag, nwin);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pixel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 2'd0 || out_col !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got v=%b d=%b r=%0d c=%0d expected 0 0 0 0",
               out_valid, frame_done, out_row, out_col);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (taps[k] !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_tap%0d: got %0d expected 0", k + 1, taps[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    test_frame(1'b0, 0, 1'b1, NPIX, "ramp");
  endtask

  task automatic test_toggle();
    test_frame(1'b1, 0, 1'b1, NPIX, "toggle");
  endtask

  // Fixed windows: the very first one and the first after the row wrap.
  task automatic test_row_wrap();
    logic [7:0] first_win [9];
    logic [7:0] wrap_win [9];
    first_win = '{8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
    wrap_win  = '{8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22, 8'd30, 8'd31, 8'd32};
    for (int i = 0; i < NPIX; i++) begin
      applyStimulus(1'b1, i == 0, 8'(10 * (i / W) + i % W));
      if (i == 12) begin
        for (int k = 0; k < 9; k++) begin
          checks++;
          if (taps[k] !== first_win[k]) begin
            errors++;
            $display("[TB] FAIL first_win_tap%0d: got %0d expected %0d", k + 1, taps[k], first_win[k]);
          end
        end
      end
      if (i == 15 || i == 16) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wrap_gate px%0d: got %b expected 0", i, out_valid);
        end
      end
      if (i == 17) begin
        checks++;
        if (out_valid !== 1'b1 || out_row !== 2'd2 || out_col !== 3'd1) begin
          errors++;
          $display("[TB] FAIL wrap_pos: got v=%b (%0d,%0d) expected 1 (2,1)", out_valid, out_row, out_col);
        end
        for (int k = 0; k < 9; k++) begin
          checks++;
          if (taps[k] !== wrap_win[k]) begin
            errors++;
            $display("[TB] FAIL wrap_win_tap%0d: got %0d expected %0d", k + 1, taps[k], wrap_win[k]);
          end
        end
      end
    end
  endtask

  task automatic test_sof_resync();
    test_frame(1'b0, 0, 1'b1, 14, "pre_abort");
    test_frame(1'b0, 50, 1'b1, NPIX, "resync");
  endtask

  task automatic test_mid_reset();
    test_frame(1'b0, 0, 1'b1, 14, "pre_reset");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd99);
    checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 2'd0 || out_col !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midreset_ctrl: got v=%b d=%b r=%0d c=%0d expected 0 0 0 0",
               out_valid, frame_done, out_row, out_col);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (taps[k] !== 8'd0) begin
        errors++;
        $display("[TB] FAIL midreset_tap%0d: got %0d expected 0", k + 1, taps[k]);
      end
    end
    rst = 1'b0;
    test_frame(1'b0, 150, 1'b0, NPIX, "post_reset");
  endtask

  task automatic test_back_to_back();
    test_frame(1'b0, 0, 1'b1, NPIX, "b2b_f1");
    test_frame(1'b0, 100, 1'b0, NPIX, "b2b_f2");
    test_frame(1'b0, 200, 1'b1, NPIX, "b2b_f3");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_toggle();
    test_row_wrap();
    test_sof_resync();
    test_mid_reset();
    test_back_to_back();
    applyStimulus(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
